// File: rtl/cdc_hs_rx_ctrl_pkg.sv
// rtl/cdc_hs_rx_ctrl_pkg.sv - shared types and constants for the REQ/ACK receive controller
package cdc_hs_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_PRESENT,
    ST_ACK_WAIT
  } state_e;

  localparam int XFER_CNT_W = 16;

  // Timeout counter only has to reach TIMEOUT_CYCLES-1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_bit_sync_srst.sv
// rtl/cdc_bit_sync_srst.sv - NUM_STAGES-deep single-bit synchronizer, sync active-high reset
module cdc_bit_sync_srst #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] sync_q;
  logic [NUM_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_hs_rx_ctrl.sv
// rtl/cdc_hs_rx_ctrl.sv - destination side of a 4-phase REQ/ACK multi-bit crossing
module cdc_hs_rx_ctrl
  import cdc_hs_rx_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH      = 8,
  parameter int NUM_STAGES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_ASYNC,
  input  logic [BUS_WIDTH-1:0]  DATA_ASYNC,
  output logic                  ACK,
  output logic [BUS_WIDTH-1:0]  DOUT,
  output logic                  DOUT_VALID,
  input  logic                  DOUT_READY,
  output logic                  BUSY,
  output logic                  ERR_TIMEOUT,
  output logic [XFER_CNT_W-1:0] XFER_CNT
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic req_s;

  state_e                state_q, state_d;
  logic [BUS_WIDTH-1:0]  dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [XFER_CNT_W-1:0] xfer_q, xfer_d;
  logic [CNT_W-1:0]      tcnt_q, tcnt_d;

  cdc_bit_sync_srst #(
    .NUM_STAGES(NUM_STAGES)
  ) u_req_sync (
    .clk(CLK),
    .rst(RST),
    .d  (REQ_ASYNC),
    .q  (req_s)
  );

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    err_d   = err_q;
    xfer_d  = xfer_q;
    tcnt_d  = tcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // req_s has been high for a full sync delay, so the source bus is settled.
        dout_d  = DATA_ASYNC;
        valid_d = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (DOUT_READY) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          xfer_d  = xfer_q + 1'b1;
          state_d = ST_ACK_WAIT;
        end
      end
      ST_ACK_WAIT: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          tcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (TIMEOUT_EN) begin
          // Flag only: the handshake keeps waiting for the source to drop REQ.
          if (tcnt_q == CNT_LAST) begin
            err_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      xfer_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      xfer_q  <= xfer_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign ACK         = ack_q;
  assign DOUT        = dout_q;
  assign DOUT_VALID  = valid_q;
  assign BUSY        = (state_q != ST_IDLE);
  assign ERR_TIMEOUT = err_q;
  assign XFER_CNT    = xfer_q;

endmodule
